// File: rtl/pixel_line_buffer_if.sv
// Bus between the glyph renderer / video stage and the ping-pong pixel line buffer.
// The master drives the write words and the video-side controls. The slave is the buffer.
interface pixel_line_buffer_if #(
  parameter int PIXEL_BITS      = 4,
  parameter int PIXELS_PER_WORD = 16
);
  logic                                  wr_valid;
  logic                                  wr_ready;
  logic [PIXEL_BITS*PIXELS_PER_WORD-1:0] wr_data;
  logic                                  line_full;
  logic                                  rd_start;
  logic                                  rd_enable;
  logic [PIXEL_BITS-1:0]                 pixel;
  logic                                  pixel_valid;
  logic                                  underrun;

  modport master (
    output wr_valid, wr_data, rd_start, rd_enable,
    input  wr_ready, line_full, pixel, pixel_valid, underrun
  );

  modport slave (
    input  wr_valid, wr_data, rd_start, rd_enable,
    output wr_ready, line_full, pixel, pixel_valid, underrun
  );
endinterface

// File: rtl/pixel_line_buffer.sv
// Double-buffered pixel line buffer.
// Wide words fill one bank while the other bank streams one pixel per enabled cycle.
// The banks swap on rd_start, but only when the fill bank holds a complete line.
// Otherwise the previous line is repeated and underrun pulses for one cycle.
module pixel_line_buffer #(
  parameter int PIXEL_BITS      = 4,
  parameter int PIXELS_PER_WORD = 16,
  parameter int WORDS_PER_LINE  = 80
) (
  input logic               clk,
  input logic               reset,
  pixel_line_buffer_if.slave bus
);
  localparam int LINE_PIXELS = PIXELS_PER_WORD * WORDS_PER_LINE;
  localparam int WORD_BITS   = PIXEL_BITS * PIXELS_PER_WORD;
  localparam int CNT_W       = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
  localparam int IDX_W       = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
  localparam int LANE_W      = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam int ADDR_W      = $clog2(2 * WORDS_PER_LINE);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t                state;
  state_t                next_state;
  logic                  fill_bank;
  logic [CNT_W-1:0]      wr_count;
  logic                  line_full_q;
  logic                  show_valid;
  logic [IDX_W-1:0]      rd_index;
  logic [PIXEL_BITS-1:0] pixel_q;
  logic                  pixel_valid_q;
  logic                  underrun_q;

  // Both banks share one array: bank 0 occupies the low half and bank 1 the high half.
  logic [WORD_BITS-1:0]  mem [2*WORDS_PER_LINE];

  logic                  wr_ready;
  logic                  accept;
  logic                  last_word;
  logic                  complete;
  logic                  swap;
  logic                  rd_fire;
  logic                  rd_last;
  logic [ADDR_W-1:0]     wr_addr;
  logic [ADDR_W-1:0]     rd_addr;
  logic [LANE_W-1:0]     rd_lane;
  logic [WORD_BITS-1:0]  rd_word;
  logic [PIXEL_BITS-1:0] pixel_next;
  logic                  pixel_valid_next;
  logic                  underrun_next;

  assign wr_ready  = reset & ~line_full_q;
  assign accept    = bus.wr_valid & wr_ready;
  assign last_word = (wr_count == CNT_W'(WORDS_PER_LINE - 1));
  // A word that lands in the same cycle as rd_start still completes the line for that swap.
  assign complete  = line_full_q | (accept & last_word);
  assign swap      = bus.rd_start & complete;
  assign rd_last   = (rd_index == IDX_W'(LINE_PIXELS - 1));

  assign wr_addr = (fill_bank ? ADDR_W'(WORDS_PER_LINE) : ADDR_W'(0)) + ADDR_W'(wr_count);
  assign rd_addr = (fill_bank ? ADDR_W'(0) : ADDR_W'(WORDS_PER_LINE))
                   + ADDR_W'(rd_index / PIXELS_PER_WORD);
  assign rd_lane = LANE_W'(rd_index % PIXELS_PER_WORD);
  assign rd_word = mem[rd_addr];

  assign bus.wr_ready    = wr_ready;
  assign bus.line_full   = line_full_q;
  assign bus.pixel       = pixel_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.underrun    = underrun_q;

  // Display state register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // rd_start always re-decides the state. Otherwise, reading the last pixel ends the line.
  always_comb begin
    next_state = state;
    if (bus.rd_start) begin
      if (complete || show_valid) next_state = SHOW;
      else                        next_state = IDLE;
    end else if (rd_fire && rd_last) begin
      next_state = IDLE;
    end
  end

  // Read strobe and next output values. A restarting rd_start takes priority over rd_enable.
  always_comb begin
    rd_fire          = 1'b0;
    pixel_next       = '0;
    pixel_valid_next = 1'b0;
    underrun_next    = 1'b0;
    if (state == SHOW && bus.rd_enable && !bus.rd_start) begin
      rd_fire          = 1'b1;
      pixel_valid_next = 1'b1;
      pixel_next       = rd_word[rd_lane*PIXEL_BITS +: PIXEL_BITS];
    end
    if (bus.rd_start && !complete) underrun_next = 1'b1;
  end

  // Fill-side bookkeeping: word counter, full flag and the bank swap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fill_bank   <= 1'b0;
      wr_count    <= '0;
      line_full_q <= 1'b0;
      show_valid  <= 1'b0;
    end else if (swap) begin
      fill_bank   <= ~fill_bank;
      wr_count    <= '0;
      line_full_q <= 1'b0;
      show_valid  <= 1'b1;
    end else if (accept) begin
      if (last_word) begin
        line_full_q <= 1'b1;
        wr_count    <= '0;
      end else begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

  // Pixel storage has no reset. The write targets the fill bank only.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_addr] <= bus.wr_data;
  end

  // Show-side registers: read index and the registered pixel outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_index      <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      pixel_q       <= pixel_next;
      pixel_valid_q <= pixel_valid_next;
      underrun_q    <= underrun_next;
      if (bus.rd_start)  rd_index <= '0;
      else if (rd_fire)  rd_index <= rd_last ? '0 : rd_index + IDX_W'(1);
    end
  end
endmodule

// File: tb/tb_pixel_line_buffer.sv
// Directed bench for pixel_line_buffer.
// A vector table covers reset and idle behaviour.
// Hand-written sequences cover fills, swaps, underruns and mid-line reset.
module tb_pixel_line_buffer;
  localparam int PB  = 4;
  localparam int PPW = 16;
  localparam int WPL = 80;
  localparam int LP  = PPW * WPL;
  localparam int WB  = PB * PPW;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  pixel_line_buffer_if #(.PIXEL_BITS(PB), .PIXELS_PER_WORD(PPW)) bus();

  pixel_line_buffer #(.PIXEL_BITS(PB), .PIXELS_PER_WORD(PPW), .WORDS_PER_LINE(WPL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic       wv;
    logic       rs;
    logic       re;
    logic       exp_ready;
    logic       exp_full;
    logic       exp_pv;
    logic [3:0] exp_pixel;
    logic       exp_underrun;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input string name, input logic rst, input logic wv, input logic rs,
                              input logic re, input logic er, input logic ef, input logic epv,
                              input logic eun);
    vec_t v;
    v.name = name; v.rst = rst; v.wv = wv; v.rs = rs; v.re = re;
    v.exp_ready = er; v.exp_full = ef; v.exp_pv = epv; v.exp_pixel = 4'd0; v.exp_underrun = eun;
    return v;
  endfunction

  // Pixel value of lane k in word w for each test line pattern.
  function automatic logic [3:0] pix(input int pat, input int w, input int k);
    case (pat)
      0:       return 4'(w % 16);
      1:       return 4'((w + 3) % 16);
      2:       return 4'((w + k) % 16);
      3:       return 4'((w + 7) % 16);
      default: return 4'((w + 5) % 16);
    endcase
  endfunction

  function automatic logic [WB-1:0] make_word(input int pat, input int w);
    logic [WB-1:0] d;
    d = '0;
    for (int k = 0; k < PPW; k++) d[k*PB +: PB] = pix(pat, w, k);
    return d;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic wv, input logic [WB-1:0] wd,
                               input logic rs, input logic re);
    reset         = rst;
    bus.wr_valid  = wv;
    bus.wr_data   = wd;
    bus.rd_start  = rs;
    bus.rd_enable = re;
    @(posedge clk);
    #1;
  endtask

  task automatic readLine(input int pat, input int first, input int count, input string tag);
    for (int n = first; n < first + count; n++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
      checkOutput($sformatf("%s.pv[%0d]", tag, n), 32'(bus.pixel_valid), 32'd1);
      checkOutput($sformatf("%s.pix[%0d]", tag, n), 32'(bus.pixel), 32'(pix(pat, n / PPW, n % PPW)));
      checkOutput($sformatf("%s.un[%0d]", tag, n), 32'(bus.underrun), 32'd0);
    end
  endtask

  task automatic writeWords(input int pat, input int first, input int count);
    for (int w = first; w < first + count; w++) applyStimulus(1'b1, 1'b1, make_word(pat, w), 1'b0, 1'b0);
  endtask

  task automatic checkIdleOut(input string tag);
    checkOutput({tag, ".pv"}, 32'(bus.pixel_valid), 32'd0);
    checkOutput({tag, ".pix"}, 32'(bus.pixel), 32'd0);
  endtask

  initial begin
    logic [WB-1:0] extra;
    extra = {16{4'hA}};

    vecs[0] = mk("rst0",  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[1] = mk("rst1",  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[2] = mk("idle",  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[3] = mk("start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    vecs[4] = mk("after", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 5; i < 15; i++)
      vecs[i] = mk($sformatf("en%0d", i - 5), 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset, underrun with an empty buffer, and rd_enable ignored while nothing is shown.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].wv, '0, vecs[i].rs, vecs[i].re);
      checkOutput({vecs[i].name, ".ready"}, 32'(bus.wr_ready), 32'(vecs[i].exp_ready));
      checkOutput({vecs[i].name, ".full"}, 32'(bus.line_full), 32'(vecs[i].exp_full));
      checkOutput({vecs[i].name, ".pv"}, 32'(bus.pixel_valid), 32'(vecs[i].exp_pv));
      checkOutput({vecs[i].name, ".pix"}, 32'(bus.pixel), 32'(vecs[i].exp_pixel));
      checkOutput({vecs[i].name, ".un"}, 32'(bus.underrun), 32'(vecs[i].exp_underrun));
    end

    // Line A: fill, swap, and show the full line.
    writeWords(0, 0, WPL - 1);
    checkOutput("A.full79", 32'(bus.line_full), 32'd0);
    writeWords(0, WPL - 1, 1);
    checkOutput("A.full80", 32'(bus.line_full), 32'd1);
    checkOutput("A.ready80", 32'(bus.wr_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("A.swap.full", 32'(bus.line_full), 32'd0);
    checkOutput("A.swap.un", 32'(bus.underrun), 32'd0);
    checkOutput("A.swap.ready", 32'(bus.wr_ready), 32'd1);
    readLine(0, 0, LP, "A");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checkIdleOut("A.end");

    // Half of line B, then an underrun repeats line A. Line B is completed afterwards.
    writeWords(1, 0, WPL / 2);
    checkOutput("B.half.full", 32'(bus.line_full), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("B.under.un", 32'(bus.underrun), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("B.under.un2", 32'(bus.underrun), 32'd0);
    readLine(0, 0, 10, "Arep");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkIdleOut("Arep.hold");
    readLine(0, 10, 10, "Arep");
    writeWords(1, WPL / 2, WPL / 2);
    checkOutput("B.full", 32'(bus.line_full), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("B.swap.un", 32'(bus.underrun), 32'd0);
    readLine(1, 0, LP, "B");
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
    checkIdleOut("B.end");

    // Line C with wr_valid held past the end. The extra words must not be written.
    for (int c = 0; c < WPL + 5; c++) begin
      applyStimulus(1'b1, 1'b1, (c < WPL) ? make_word(2, c) : extra, 1'b0, 1'b0);
      if (c == WPL - 1 || c == WPL + 4) begin
        checkOutput($sformatf("C.ready[%0d]", c), 32'(bus.wr_ready), 32'd0);
        checkOutput($sformatf("C.full[%0d]", c), 32'(bus.line_full), 32'd1);
      end
    end
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("C.swap.un", 32'(bus.underrun), 32'd0);
    readLine(2, 0, 32, "C");

    // Line D: the final word is accepted in the same cycle as rd_start, which also restarts the line.
    writeWords(3, 0, WPL - 1);
    applyStimulus(1'b1, 1'b1, make_word(3, WPL - 1), 1'b1, 1'b0);
    checkOutput("D.swap.un", 32'(bus.underrun), 32'd0);
    checkOutput("D.swap.full", 32'(bus.line_full), 32'd0);
    checkOutput("D.swap.pv", 32'(bus.pixel_valid), 32'd0);

    // Show D while line E partially fills the other bank, then reset at pixel 600.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(1'b1, n < 30, make_word(4, n), 1'b0, 1'b1);
      checkOutput($sformatf("D.pv[%0d]", n), 32'(bus.pixel_valid), 32'd1);
      checkOutput($sformatf("D.pix[%0d]", n), 32'(bus.pixel), 32'(pix(3, n / PPW, n % PPW)));
      checkOutput($sformatf("D.un[%0d]", n), 32'(bus.underrun), 32'd0);
    end
    checkOutput("E.full", 32'(bus.line_full), 32'd0);
    applyStimulus(1'b0, 1'b1, make_word(4, 30), 1'b0, 1'b1);
    checkIdleOut("R.reset");
    checkOutput("R.full", 32'(bus.line_full), 32'd0);
    checkOutput("R.ready", 32'(bus.wr_ready), 32'd0);
    checkOutput("R.un", 32'(bus.underrun), 32'd0);
    applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);
    checkOutput("R.release.ready", 32'(bus.wr_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
    checkOutput("R.start.un", 32'(bus.underrun), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
      checkIdleOut($sformatf("R.en%0d", i));
      checkOutput($sformatf("R.en%0d.un", i), 32'(bus.underrun), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
